// File: rtl/freq_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_cond_pkg
// Purpose  : Shared constants and types for the frequency input conditioner:
//            register addresses, FSM state encoding, edge-select encoding
//            and the edge qualification helper.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package freq_cond_pkg;

  // Avalon-MM register map (8-bit data, 4-bit address)
  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_FILT_LEN = 4'd1;
  localparam logic [3:0] ADDR_DIV_LO   = 4'd2;
  localparam logic [3:0] ADDR_DIV_HI   = 4'd3;
  localparam logic [3:0] ADDR_STATUS   = 4'd4;
  localparam logic [3:0] ADDR_CNT_LO   = 4'd5;
  localparam logic [3:0] ADDR_CNT_HI   = 4'd6;
  localparam logic [3:0] ADDR_CNT_CLR  = 4'd7;

  // Conditioner FSM; the encoding is visible in STATUS[2:1]
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // CTRL[2:1] edge select; 2'b11 falls back to rising
  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  function automatic logic edge_qualifies(input logic [1:0] sel,
                                          input logic       rise,
                                          input logic       fall);
    case (sel)
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : freq_input_conditioner_if
// Purpose  : 8-bit Avalon-MM control/status bus of the frequency input
//            conditioner.
// Ports    : avs_ctrl_writedata, avs_ctrl_address, avs_ctrl_write,
//            avs_ctrl_read (master -> slave); avs_ctrl_readdata
//            (slave -> master, registered in the slave).
// Revision : 1.0 - initial release
// ============================================================================
interface freq_input_conditioner_if;
  logic [7:0] avs_ctrl_writedata;
  logic [7:0] avs_ctrl_readdata;
  logic [3:0] avs_ctrl_address;
  logic       avs_ctrl_write;
  logic       avs_ctrl_read;

  modport master (
    output avs_ctrl_writedata, avs_ctrl_address, avs_ctrl_write, avs_ctrl_read,
    input  avs_ctrl_readdata
  );

  modport slave (
    input  avs_ctrl_writedata, avs_ctrl_address, avs_ctrl_write, avs_ctrl_read,
    output avs_ctrl_readdata
  );
endinterface
`default_nettype wire

// File: rtl/freq_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module   : freq_glitch_filter
// Purpose  : Synchronizes the raw input pin and rejects pulses shorter than
//            filt_len+1 cycles. Also provides the previous-cycle filtered
//            level for edge detection.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            freq_in       - raw asynchronous pin
//            filt_len      - qualify length (0 = one-cycle qualify)
//            filt          - filtered level
//            filt_d        - filt delayed by one cycle
// Revision : 1.0 - initial release
// ============================================================================
module freq_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              freq_in,
  input  wire logic [FILT_W-1:0] filt_len,
  output logic                   filt,
  output logic                   filt_d
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      qual_cnt_q, qual_cnt_d;
  logic                   filt_lvl_q, filt_lvl_d;
  logic                   filt_prev_q, filt_prev_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], freq_in};
    filt_prev_d = filt_lvl_q;
    qual_cnt_d  = qual_cnt_q;
    filt_lvl_d  = filt_lvl_q;
    if (sync_out == filt_lvl_q) begin
      qual_cnt_d = '0;
    end else if (qual_cnt_q >= filt_len) begin
      // '>=' keeps a shortened FILT_LEN from stranding a larger count
      filt_lvl_d = sync_out;
      qual_cnt_d = '0;
    end else begin
      qual_cnt_d = qual_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      qual_cnt_q  <= '0;
      filt_lvl_q  <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      qual_cnt_q  <= qual_cnt_d;
      filt_lvl_q  <= filt_lvl_d;
      filt_prev_q <= filt_prev_d;
    end
  end

  assign filt   = filt_lvl_q;
  assign filt_d = filt_prev_q;

endmodule
`default_nettype wire

// File: rtl/freq_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : freq_input_conditioner
// Purpose  : Conditions the raw frequency pin (sync, glitch filter, edge
//            select) and divides qualifying edges with a programmable
//            prescaler, producing a square wave and a wrap strobe.
//            Optional macro FREQ_COND_EDGE_CNT_EN adds the 16-bit saturating
//            edge counter (addresses 5/6/7, STATUS[3]).
// Ports    : csi_MCLK_clk    - clock
//            rsi_MRST_reset  - synchronous active-high reset
//            avs             - Avalon-MM slave (8-bit registers)
//            freq_in         - raw asynchronous input
//            freq_out        - divided square wave
//            edge_strobe     - one-cycle pulse per prescaler wrap
// Revision : 1.0 - initial release
// ============================================================================
module freq_input_conditioner
  import freq_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int DIV_W       = 16
) (
  input  wire logic                 csi_MCLK_clk,
  input  wire logic                 rsi_MRST_reset,
  freq_input_conditioner_if.slave   avs,
  input  wire logic                 freq_in,
  output logic                      freq_out,
  output logic                      edge_strobe
);

  localparam int SET_W = FILT_W + 8;

  logic [2:0]        ctrl_q, ctrl_d;
  logic [FILT_W-1:0] filt_len_q, filt_len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        readdata_q, readdata_d;
  state_e            state_q, state_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [DIV_W-1:0]  presc_cnt_q, presc_cnt_d;
  logic              freq_out_q, freq_out_d;
  logic              strobe_q, strobe_d;

  logic              filt, filt_d;
  logic              enable, qual_edge, run_active, run_edge, settle_done;
  logic [SET_W-1:0]  settle_limit;
  logic [DIV_W-1:0]  div_last;
  logic [15:0]       edge_cnt;
  logic              cnt_sat;
  logic [7:0]        rd_mux;

  freq_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_filter (
    .clk      (csi_MCLK_clk),
    .rst      (rsi_MRST_reset),
    .freq_in  (freq_in),
    .filt_len (filt_len_q),
    .filt     (filt),
    .filt_d   (filt_d)
  );

  assign enable    = ctrl_q[0];
  assign qual_edge = edge_qualifies(ctrl_q[2:1], filt & ~filt_d, ~filt & filt_d);

  // ---- register writes ----
  always_comb begin
    ctrl_d     = ctrl_q;
    filt_len_d = filt_len_q;
    div_d      = div_q;
    if (avs.avs_ctrl_write) begin
      case (avs.avs_ctrl_address)
        ADDR_CTRL:     ctrl_d       = avs.avs_ctrl_writedata[2:0];
        ADDR_FILT_LEN: filt_len_d   = FILT_W'(avs.avs_ctrl_writedata);
        ADDR_DIV_LO:   div_d[7:0]   = avs.avs_ctrl_writedata;
        ADDR_DIV_HI:   div_d[15:8]  = avs.avs_ctrl_writedata;
        default: ;
      endcase
    end
  end

  // ---- FSM: next state ----
  // Settle spans SYNC_STAGES+FILT_LEN+1 cycles so pre-enable samples drain.
  assign settle_limit = SET_W'(SYNC_STAGES) + SET_W'(filt_len_q);
  assign settle_done  = (settle_cnt_q >= settle_limit);

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SETTLE;
        ST_SETTLE: if (settle_done) state_d = ST_RUN;
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
    settle_cnt_d = (state_q == ST_SETTLE) ? settle_cnt_q + 1'b1 : '0;
  end

  // ---- FSM: outputs ----
  always_comb begin
    run_active = (state_q == ST_RUN) && enable;
    run_edge   = run_active && qual_edge;
  end

  // ---- prescaler ----
  // DIV==0 is treated as 1; '>=' lets a shrunk divisor wrap on the next edge.
  assign div_last = (div_q == '0) ? '0 : div_q - 1'b1;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    freq_out_d  = freq_out_q;
    strobe_d    = 1'b0;
    if (!run_active) begin
      presc_cnt_d = '0;
      freq_out_d  = 1'b0;
    end else if (qual_edge) begin
      if (presc_cnt_q >= div_last) begin
        presc_cnt_d = '0;
        freq_out_d  = ~freq_out_q;
        strobe_d    = 1'b1;
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
    end
  end

  // ---- optional edge counter ----
`ifdef FREQ_COND_EDGE_CNT_EN
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic        cnt_sat_q, cnt_sat_d;
  logic        cnt_clr;

  always_comb begin
    cnt_clr    = avs.avs_ctrl_write && (avs.avs_ctrl_address == ADDR_CNT_CLR);
    edge_cnt_d = edge_cnt_q;
    cnt_sat_d  = cnt_sat_q;
    if (cnt_clr) begin
      edge_cnt_d = '0;
      cnt_sat_d  = 1'b0;
    end else if (run_edge) begin
      if (edge_cnt_q != 16'hFFFF) edge_cnt_d = edge_cnt_q + 1'b1;
      // flag as soon as the count reaches full scale
      if (edge_cnt_q >= 16'hFFFE) cnt_sat_d = 1'b1;
    end
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      edge_cnt_q <= '0;
      cnt_sat_q  <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      cnt_sat_q  <= cnt_sat_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign cnt_sat  = cnt_sat_q;
`else
  assign edge_cnt = '0;
  assign cnt_sat  = 1'b0;
`endif

  // ---- read path (write wins over a simultaneous read) ----
  always_comb begin
    case (avs.avs_ctrl_address)
      ADDR_CTRL:     rd_mux = {5'b0, ctrl_q};
      ADDR_FILT_LEN: rd_mux = 8'(filt_len_q);
      ADDR_DIV_LO:   rd_mux = div_q[7:0];
      ADDR_DIV_HI:   rd_mux = div_q[15:8];
      ADDR_STATUS:   rd_mux = {4'b0, cnt_sat, state_q, filt};
      ADDR_CNT_LO:   rd_mux = edge_cnt[7:0];
      ADDR_CNT_HI:   rd_mux = edge_cnt[15:8];
      default:       rd_mux = 8'h00;
    endcase
    readdata_d = readdata_q;
    if (avs.avs_ctrl_read && !avs.avs_ctrl_write) readdata_d = rd_mux;
  end

  // ---- state register ----
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      ctrl_q       <= '0;
      filt_len_q   <= '0;
      div_q        <= '0;
      readdata_q   <= '0;
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      presc_cnt_q  <= '0;
      freq_out_q   <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      filt_len_q   <= filt_len_d;
      div_q        <= div_d;
      readdata_q   <= readdata_d;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      presc_cnt_q  <= presc_cnt_d;
      freq_out_q   <= freq_out_d;
      strobe_q     <= strobe_d;
    end
  end

  assign avs.avs_ctrl_readdata = readdata_q;
  assign freq_out              = freq_out_q;
  assign edge_strobe           = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_input_conditioner
// Purpose  : Self-checking bench for freq_input_conditioner. Expected toggle,
//            strobe and edge counts come from a behavioural model: number of
//            clean input pulses x edges-per-pulse, divided by the divisor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_input_conditioner;
  import freq_cond_pkg::*;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freq_in = 1'b0;
  logic freq_out, edge_strobe;

  int n_tests = 0;
  int n_fail  = 0;

  freq_input_conditioner_if avs_if ();

  freq_input_conditioner #(
    .SYNC_STAGES (SYNC),
    .FILT_W      (8),
    .DIV_W       (16)
  ) dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .avs            (avs_if),
    .freq_in        (freq_in),
    .freq_out       (freq_out),
    .edge_strobe    (edge_strobe)
  );

  always #5 clk = ~clk;

  // Cumulative output activity, sampled on the inactive edge
  int   tog_total  = 0;
  int   strb_total = 0;
  logic fo_prev    = 1'b0;
  always @(negedge clk) begin
    if (freq_out !== fo_prev) tog_total++;
    fo_prev = freq_out;
    if (edge_strobe === 1'b1) strb_total++;
  end

  int tog_base, strb_base;

  function automatic logic [15:0] exp_cnt(input int edges);
`ifdef FREQ_COND_EDGE_CNT_EN
    return (edges > 65535) ? 16'hFFFF : 16'(edges);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic int edges_per_pulse(input logic [1:0] sel);
    return (sel == EDGE_BOTH) ? 2 : 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic avs_write(input logic [3:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    avs_if.avs_ctrl_address   = addr;
    avs_if.avs_ctrl_writedata = data;
    avs_if.avs_ctrl_write     = 1'b1;
    @(posedge clk); #1;
    avs_if.avs_ctrl_write     = 1'b0;
  endtask

  task automatic avs_read(input logic [3:0] addr, output logic [7:0] data);
    @(posedge clk); #1;
    avs_if.avs_ctrl_address = addr;
    avs_if.avs_ctrl_read    = 1'b1;
    @(posedge clk); #1;
    avs_if.avs_ctrl_read    = 1'b0;
    data = avs_if.avs_ctrl_readdata;
  endtask

  task automatic read_cnt(output logic [15:0] v);
    logic [7:0] lo, hi;
    avs_read(ADDR_CNT_LO, lo);
    avs_read(ADDR_CNT_HI, hi);
    v = {hi, lo};
  endtask

  task automatic pulse(input int hi, input int lo);
    freq_in = 1'b1; tick(hi);
    freq_in = 1'b0; tick(lo);
  endtask

  // Disable, program, clear counter, enable, wait out SETTLE, snapshot bases
  task automatic configure(input logic [1:0] sel, input int flen, input int div);
    freq_in = 1'b0;
    avs_write(ADDR_CTRL, 8'h00);
    avs_write(ADDR_FILT_LEN, 8'(flen));
    avs_write(ADDR_DIV_LO, 8'(div));
    avs_write(ADDR_DIV_HI, 8'(div >> 8));
    avs_write(ADDR_CNT_CLR, 8'h5A);
    avs_write(ADDR_CTRL, {5'b0, sel, 1'b1});
    tick(SYNC + flen + 10);
    tog_base  = tog_total;
    strb_base = strb_total;
  endtask

  task automatic check_activity(input string name, input int exp_tog, input int exp_edges);
    logic [15:0] c;
    n_tests++;
    if (tog_total - tog_base !== exp_tog) begin
      n_fail++;
      $display("FAIL %s toggles: got %0d expected %0d", name, tog_total - tog_base, exp_tog);
    end
    n_tests++;
    if (strb_total - strb_base !== exp_tog) begin
      n_fail++;
      $display("FAIL %s strobes: got %0d expected %0d", name, strb_total - strb_base, exp_tog);
    end
    n_tests++;
    if (freq_out !== logic'(exp_tog % 2)) begin
      n_fail++;
      $display("FAIL %s freq_out: got %b expected %0d", name, freq_out, exp_tog % 2);
    end
    read_cnt(c);
    n_tests++;
    if (c !== exp_cnt(exp_edges)) begin
      n_fail++;
      $display("FAIL %s edge_cnt: got %h expected %h", name, c, exp_cnt(exp_edges));
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    n_tests++;
    if (freq_out !== 1'b0 || edge_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got freq_out=%b strobe=%b expected 0/0", freq_out, edge_strobe);
    end
    for (int a = 0; a < 8; a++) begin
      avs_read(4'(a), d);
      n_tests++;
      if (d !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got %h expected 00", a, d);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    configure(EDGE_RISE, 0, 1);
    avs_read(ADDR_STATUS, d);
    n_tests++;
    if (d !== 8'h04) begin
      n_fail++;
      $display("FAIL basic_status_run: got %h expected 04", d);
    end
    repeat (10) pulse(4, 4);
    tick(8);
    check_activity("basic", 10, 10);
  endtask

  task automatic test_both_div3();
    configure(EDGE_BOTH, 0, 3);
    repeat (6) pulse(4, 4);
    tick(8);
    check_activity("both_div3", 4, 12);
    // count must be 0: two more edges do not wrap, the third does
    pulse(4, 4);
    tick(4);
    check_activity("both_div3_nowrap", 4, 14);
    pulse(4, 4);
    tick(4);
    check_activity("both_div3_wrap", 5, 16);
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    int ng;
    configure(EDGE_RISE, 4, 1);
    ng = $urandom_range(3, 6);
    repeat (ng) pulse(3, 8);
    avs_read(ADDR_STATUS, d);
    n_tests++;
    if (d[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_filt_level: got %b expected 0", d[0]);
    end
    check_activity("glitch_reject", 0, 0);
    pulse(5, 14);
    check_activity("glitch_pass", 1, 1);
  endtask

  task automatic test_div0();
    int n;
    configure(EDGE_RISE, 0, 0);
    n = $urandom_range(3, 9);
    repeat (n) pulse(4, 4);
    tick(8);
    check_activity("div0", n, n);
  endtask

  task automatic test_div_change();
    configure(EDGE_RISE, 0, 10);
    repeat (5) pulse(4, 4);
    tick(4);
    check_activity("divchg_before", 0, 5);
    avs_write(ADDR_DIV_LO, 8'd2);
    pulse(4, 4);
    tick(4);
    check_activity("divchg_wrap", 1, 6);
    repeat (2) pulse(4, 4);
    tick(4);
    check_activity("divchg_after", 2, 8);
  endtask

  task automatic test_random();
    logic [1:0] sel;
    int flen, div, np, edges;
    for (int it = 0; it < 6; it++) begin
      sel  = 2'($urandom_range(0, 3));
      flen = $urandom_range(0, 3);
      div  = $urandom_range(1, 5);
      np   = $urandom_range(1, 10);
      configure(sel, flen, div);
      for (int p = 0; p < np; p++)
        pulse($urandom_range(flen + 2, flen + 6), $urandom_range(flen + 2, flen + 6));
      tick(flen + 10);
      edges = np * edges_per_pulse(sel);
      check_activity("random", edges / div, edges);
    end
  endtask

  task automatic test_counter();
    logic [15:0] c;
    logic [7:0]  d;
`ifdef FREQ_COND_EDGE_CNT_EN
    configure(EDGE_BOTH, 0, 1);
    repeat (65600) begin
      freq_in = ~freq_in;
      tick(1);
    end
    freq_in = 1'b0;
    tick(10);
    avs_write(ADDR_CTRL, 8'h00);
    read_cnt(c);
    n_tests++;
    if (c !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %h expected FFFF", c);
    end
    avs_read(ADDR_STATUS, d);
    n_tests++;
    if (d[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_sat_set: got %b expected 1", d[3]);
    end
    avs_write(ADDR_CNT_CLR, 8'h01);
    read_cnt(c);
    n_tests++;
    if (c !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_clear: got %h expected 0000", c);
    end
    avs_read(ADDR_STATUS, d);
    n_tests++;
    if (d[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_sat_clear: got %b expected 0", d[3]);
    end
`else
    configure(EDGE_RISE, 0, 1);
    repeat (4) pulse(4, 4);
    tick(4);
    avs_read(ADDR_CNT_LO, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL cnt_absent_lo: got %h expected 00", d);
    end
    read_cnt(c);
    n_tests++;
    if (c !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_absent: got %h expected 0000", c);
    end
    avs_read(ADDR_STATUS, d);
    n_tests++;
    if (d[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_sat_absent: got %b expected 0", d[3]);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d;
    configure(EDGE_RISE, 0, 1);
    pulse(4, 4);
    avs_read(ADDR_CTRL, d);
    n_tests++;
    if (freq_out !== 1'b1 || d !== 8'h01) begin
      n_fail++;
      $display("FAIL midrun_pre: got freq_out=%b ctrl=%h expected 1/01", freq_out, d);
    end
    rst = 1'b1;
    tick(1);
    n_tests++;
    if (freq_out !== 1'b0 || edge_strobe !== 1'b0 || avs_if.avs_ctrl_readdata !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_reset: got freq_out=%b strobe=%b rd=%h expected 0/0/00",
               freq_out, edge_strobe, avs_if.avs_ctrl_readdata);
    end
    rst = 1'b0;
    avs_read(ADDR_STATUS, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_status: got %h expected 00", d);
    end
  endtask

  initial begin
    avs_if.avs_ctrl_write     = 1'b0;
    avs_if.avs_ctrl_read      = 1'b0;
    avs_if.avs_ctrl_address   = 4'h0;
    avs_if.avs_ctrl_writedata = 8'h00;
    test_reset();
    test_basic();
    test_both_div3();
    test_glitch();
    test_div0();
    test_div_change();
    test_random();
    test_counter();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_input_conditioner.md
Name: freq_input_conditioner

Overview:
- Upstream stage of the frequency-measurement block. It conditions the raw external `frequent` pin before measurement.
- Conditioning steps, in order: synchronize to csi_MCLK_clk, glitch-filter, select edges, then divide with a programmable prescaler.
- Produces a clean divided square wave (freq_out) that drives the measurement block's `frequent` input, plus a one-cycle wrap strobe.
- Configured and monitored through an 8-bit Avalon-MM slave on the same Qsys bus.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer (>=2).
- FILT_W, 8, width of the glitch-filter length register and counter.
- DIV_W, 16, width of the prescaler divisor and counter (fixed 16 for the register map).

Ports:
- csi_MCLK_clk  in  1  sole clock.
- rsi_MRST_reset  in  1  synchronous, active-high reset.
- avs_ctrl_writedata  in  8  Avalon write data.
- avs_ctrl_readdata  out  8  Avalon read data, registered.
- avs_ctrl_address  in  4  register address.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe.
- freq_in  in  1  raw asynchronous input pin.
- freq_out  out  1  conditioned/divided square wave to the measurement stage.
- edge_strobe  out  1  one-cycle pulse on each prescaler wrap.

Behaviour:
- Reset (sync, active-high): all registers 0; freq_out=0; edge_strobe=0; avs_ctrl_readdata=0; FSM=IDLE; synchronizer flops=0.
- Register map, 8-bit:
  - 0 CTRL: [0] enable; [2:1] edge select (00 rise, 01 fall, 10 both, 11 rise).
  - 1 FILT_LEN.
  - 2 DIV_LO, 3 DIV_HI.
  - 4 STATUS (read-only): [0] filtered level; [2:1] state; [3] cnt_sat.
  - 5/6 EDGE_CNT lo/hi.
  - 7 write any value = clear edge counter and cnt_sat.
  - Unmapped addresses read 0; writes to them are ignored.
- Read: readdata is updated on the cycle after avs_ctrl_read and holds its value otherwise. Write takes precedence if write and read are asserted together.
- Synchronizer: SYNC_STAGES flops. sync_q = last stage.
- Glitch filter: filt changes to sync_q only after sync_q has differed from filt for FILT_LEN+1 consecutive cycles. The counter resets whenever sync_q equals filt. FILT_LEN=0 means a 1-cycle qualify, so filt lags sync_q by 1 cycle.
- Edge detect: compares filt with filt_d (the previous-cycle value). A qualifying edge is one matching CTRL[2:1].
- FSM:
  - IDLE: freq_out held 0, prescaler count=0. Leaves for SETTLE when enable=1.
  - SETTLE: waits SYNC_STAGES+FILT_LEN+1 cycles so stale samples are flushed; edges are ignored. Goes to RUN when the wait ends.
  - RUN: edges are processed.
  - enable=0 in any state returns to IDLE on the next cycle. freq_out is forced 0 and the count cleared.
- Prescaler (RUN only): effective div = (DIV==0) ? 1 : DIV.
  - On a qualifying edge with count==div-1: count<=0, freq_out toggles, edge_strobe=1 for exactly that cycle.
  - On any other qualifying edge: count++.
  - Result: freq_out frequency = qualifying-edge rate / (2*div).
- DIV write during RUN takes effect immediately on the compare. If count>=new div-1, the next qualifying edge wraps.
- Edge counter: 16-bit, increments on qualifying edges in RUN. Saturates at 0xFFFF and sets cnt_sat. If a clear (addr 7) coincides with an edge, the clear wins and the counter becomes 0.
- Reset mid-RUN: every output returns to its reset value on the next edge. No partial pulse is emitted.

Optional Feature:
- Macro: FREQ_COND_EDGE_CNT_EN.
- Defined: edge counter, cnt_sat, and addresses 5/6/7 are implemented as described.
- Undefined: no counter logic. Addresses 5/6 read 0, address 7 writes are ignored, and STATUS[3]=0.

Decomposition:
- Package freq_cond_pkg holds:
  - address constants (ADDR_CTRL..ADDR_CNT_CLR);
  - FSM state enum (IDLE=0, SETTLE=1, RUN=2);
  - edge-select encoding constants.
- One sub-module, freq_glitch_filter: synchronizer plus qualify counter. Outputs filt and filt_d.

Test Plan:
- Reset then read addresses 0-7 -> every read returns 0x00; freq_out=0.
- DIV=1, rise, FILT_LEN=0, enable, then 10 clean 8-cycle-period pulses after SETTLE -> freq_out toggles 10 times; edge_strobe pulses 10 times; EDGE_CNT=10.
- DIV=3, both-edge select, 6 input pulses -> 12 qualifying edges -> 4 toggles; count=0 at end.
- FILT_LEN=4 with 3-cycle glitches injected -> filt unchanged, no strobe; a 5-cycle-wide pulse -> exactly 1 qualifying rising edge.
- DIV=0 -> behaves as DIV=1. DIV changed from 10 to 2 while count=5 -> wrap on the next edge.
- FREQ_COND_EDGE_CNT_EN defined: 65540 edges -> EDGE_CNT=0xFFFF with cnt_sat=1; write to address 7 -> EDGE_CNT=0, cnt_sat=0. Undefined: address 5 reads 0.
